lsu_mem_ctrl: RTL and testbench

Load/store initiator sitting between the core's execute stage and the word-organised data memory. It accepts one RV32 load or store per handshake, drives the memory's word-wide MemRead/MemWrite interface, performs byte/halfword lane extraction with sign or zero extension on loads, and performs read-modify-write for sub-word stores. A one-cycle response pulse returns load data or an error flag to the core.

---
 rtl/lsu_mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one RV32 load/store per handshake onto a word-wide MemRead/MemWrite port,
// with lane extract/extend on loads and read-modify-write for SB/SH. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W.
module lsu_mem_ctrl #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [8:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          store_q, store_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [8:0]    mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          req_err;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [15:0] wd);
        logic [31:0] m;
        m = w;
        if (sz == 2'b00)
            m[{off, 3'b000} +: 8] = wd[7:0];
        else if (off[1])
            m[31:16] = wd;
        else
            m[15:0] = wd;
        return m;
    endfunction

    always_comb begin
        if (req_store)
            req_err = (req_funct3 > 3'b010);
        else
            req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Outputs are computed for the state being entered so they come straight from flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    store_d     = req_store;
                    f3_d        = req_funct3;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata[15:0];
                    mem_addr_d  = {req_addr[8:2], 2'b00};
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_store && req_funct3 == 3'b010) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (cnt_q == CNT_LAST) begin
                    // The read word is consumed directly: extracted for loads, merged into mem_wdata for RMW.
                    if (store_q) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = merge(mem_rdata, f3_q[1:0], off_q, wdata_q);
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = extract(mem_rdata, f3_q, off_q);
                    end
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    mem_read_d = 1'b1;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 9'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: word memory with READ_LATENCY-delayed read data and a byte-level reference model.
module tb_lsu_mem_ctrl;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: read data is only valid in the RL-th consecutive MemRead cycle.
    logic [31:0] mem [128];
    logic        init_we = 1'b0;
    logic [6:0]  init_idx = 7'h0;
    logic [31:0] init_dat = 32'h0;
    int          rd_age = 0;

    always @(posedge clk) begin
        if (init_we)
            mem[init_idx] <= init_dat;
        else if (MemWrite)
            mem[mem_addr[8:2]] <= mem_wdata;
        rd_age <= MemRead ? rd_age + 1 : 0;
    end

    assign mem_rdata = (MemRead && rd_age == RL - 1) ? mem[mem_addr[8:2]] : 32'hDEADBEEF;

    logic [31:0] ref_mem [128];
    int          checks = 0;
    int          errors = 0;
    logic        last_err;
    int          last_lat, last_nrd, last_nwr;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-lane arithmetic on the model memory.
    task automatic model(input logic st, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr, output logic [31:0] nw);
        int          nbytes, off;
        logic [31:0] w, mask, val;
        err = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (f3[1:0] == 2'd1 && a[0]) err = 1'b1;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) err = 1'b1;
`endif
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off    = (nbytes == 1) ? int'(a[1:0]) : (nbytes == 2) ? 2 * int'(a[1]) : 0;
        mask   = (nbytes == 4) ? 32'hFFFFFFFF : (32'h1 << (8 * nbytes)) - 32'h1;
        w      = ref_mem[a[8:2]];
        val    = (w >> (8 * off)) & mask;
        if (!f3[2] && nbytes < 4 && val[8 * nbytes - 1])
            val = val | ~mask;
        nw    = w;
        rdata = 32'h0;
        nrd   = 0;
        nwr   = 0;
        if (err) begin
            lat = 1;
        end else if (!st) begin
            lat = RL + 1; nrd = RL; rdata = val;
        end else if (nbytes == 4) begin
            lat = 2; nwr = 1; nw = wd;
        end else begin
            lat = RL + 2; nrd = RL; nwr = 1;
            nw = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd);
        logic        e_err;
        logic [31:0] e_rdata, e_word;
        int          e_lat, e_nrd, e_nwr;
        int          wt, lat, nrd, nwr, both, early, bad_addr;
        logic        g_err;
        logic [31:0] g_rdata;
        model(st, f3, a, wd, e_err, e_rdata, e_lat, e_nrd, e_nwr, e_word);
        wt = 0;
        while (!req_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the request fields so that only captured values can be used.
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = 9'($urandom); req_wdata = $urandom;
        lat = 0; nrd = 0; nwr = 0; both = 0; early = 0; bad_addr = 0;
        g_err = 1'b0; g_rdata = 32'h0;
        for (int n = 1; n <= RL + 8; n++) begin
            @(negedge clk);
            if (MemRead) nrd++;
            if (MemWrite) nwr++;
            if (MemRead && MemWrite) both++;
            if ((MemRead || MemWrite) && mem_addr !== {a[8:2], 2'b00}) bad_addr++;
            if (req_ready) early++;
            if (resp_valid) begin
                lat = n; g_err = resp_err; g_rdata = resp_rdata;
                break;
            end
        end
        chk("resp_latency", lat, e_lat);
        chk("resp_err", g_err, e_err);
        chk("resp_rdata", g_rdata, e_rdata);
        chk("memread_cycles", nrd, e_nrd);
        chk("memwrite_cycles", nwr, e_nwr);
        chk("read_write_overlap", both, 0);
        chk("mem_addr", bad_addr, 0);
        chk("ready_while_busy", early, 0);
        @(negedge clk);
        chk("resp_valid_after", resp_valid, 0);
        chk("resp_rdata_after", resp_rdata, 0);
        chk("resp_err_after", resp_err, 0);
        chk("ready_after_resp", req_ready, 1);
        chk("mem_word", mem[a[8:2]], e_word);
        ref_mem[a[8:2]] = e_word;
        last_err = g_err; last_lat = lat; last_nrd = nrd; last_nwr = nwr; last_rdata = g_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 9'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        for (int i = 0; i < 128; i++) begin
            init_we = 1'b1; init_idx = 7'(i);
            init_dat = (i == 5) ? 32'h80FF7F01 : $urandom;
            ref_mem[i] = init_dat;
            @(negedge clk);
        end
        init_we = 1'b0;

        // Directed loads from word 5 = 0x80FF7F01
        do_req(1'b0, 3'b000, 9'h015, 32'h0); chk("LB_015", last_rdata, 32'h0000007F);
        do_req(1'b0, 3'b000, 9'h017, 32'h0); chk("LB_017", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 9'h017, 32'h0); chk("LBU_017", last_rdata, 32'h00000080);
        do_req(1'b0, 3'b001, 9'h016, 32'h0); chk("LH_016", last_rdata, 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 9'h016, 32'h0); chk("LHU_016", last_rdata, 32'h000080FF);
        do_req(1'b0, 3'b010, 9'h014, 32'h0); chk("LW_014", last_rdata, 32'h80FF7F01);
        chk("LW_latency_rl3", last_lat, 4);
        chk("LW_memread_rl3", last_nrd, 3);

        // Directed stores
        do_req(1'b1, 3'b000, 9'h014, 32'h000000AB); chk("SB_014_word", mem[5], 32'h80FF7FAB);
        do_req(1'b1, 3'b010, 9'h014, 32'h80FF7F01); chk("SW_014_word", mem[5], 32'h80FF7F01);
        chk("SW_no_read", last_nrd, 0);
        do_req(1'b1, 3'b001, 9'h016, 32'h00001234); chk("SH_016_word", mem[5], 32'h12347F01);
        do_req(1'b1, 3'b010, 9'h016, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("SW_016_err", last_err, 1);
        chk("SW_016_no_write", last_nwr, 0);
`else
        chk("SW_016_word", mem[5], 32'hCAFEF00D);
`endif
        do_req(1'b1, 3'b100, 9'h014, 32'h11111111);
        chk("store_f3_100_err", last_err, 1);
        chk("store_f3_100_latency", last_lat, 1);
        do_req(1'b0, 3'b011, 9'h020, 32'h0);
        chk("load_f3_011_err", last_err, 1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++)
            do_req(1'($urandom), 3'($urandom), 9'($urandom), $urandom);

        // Reset during the write phase of an SB: nothing may be written or answered
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 9'h021; req_wdata = 32'h0000005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        q = 0;
        while (!MemWrite && q < RL + 5) begin
            @(negedge clk);
            q++;
        end
        chk("sb_reached_wr", MemWrite, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_memwrite", MemWrite, 0);
        chk("rst_mid_memread", MemRead, 0);
        @(negedge clk);
        rst = 1'b0;
        q = 0;
        for (int n = 0; n < RL + 4; n++) begin
            @(negedge clk);
            if (resp_valid) q++;
        end
        chk("rst_mid_no_resp", q, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_mem_unchanged", mem[8], ref_mem[8]);

        // Reset during the read phase of a load, then confirm normal service resumes
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 9'h030;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rd_memread", MemRead, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_resp_valid", resp_valid, 0);
        do_req(1'b0, 3'b010, 9'h030, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
